// File: rtl/rgbw_pkg.sv
// Shared RGBW lamp-controller constants: channel count, duty width and channel indices
// used by colorGen, rgbw_duty_fader and pwmGen.
package rgbw_pkg;
   localparam int N_CH   = 4;
   localparam int DUTY_W = 8;

   localparam int RED   = 0;
   localparam int GREEN = 1;
   localparam int BLUE  = 2;
   localparam int WHITE = 3;

   typedef logic [DUTY_W-1:0] duty_t;
endpackage

// File: rtl/rgbw_duty_fader_if.sv
// Target/duty bundle between colorGen (master side) and rgbw_duty_fader (slave side).
interface rgbw_duty_fader_if;
   logic             clk_half;
   logic             fade_en;
   rgbw_pkg::duty_t  target0;
   rgbw_pkg::duty_t  target1;
   rgbw_pkg::duty_t  target2;
   rgbw_pkg::duty_t  target3;
   rgbw_pkg::duty_t  duty0;
   rgbw_pkg::duty_t  duty1;
   rgbw_pkg::duty_t  duty2;
   rgbw_pkg::duty_t  duty3;
   logic             settled;

   modport master (
      output clk_half, fade_en, target0, target1, target2, target3,
      input  duty0, duty1, duty2, duty3, settled
   );

   modport slave (
      input  clk_half, fade_en, target0, target1, target2, target3,
      output duty0, duty1, duty2, duty3, settled
   );
endinterface

// File: rtl/rgbw_gamma_lut.sv
// Gamma curve y = (x*x + 255) >> 8, square built from shift-add partial products.
module rgbw_gamma_lut
   import rgbw_pkg::*;
(
   input  duty_t x,
   output duty_t y
);
   localparam int SQ_W = 2 * DUTY_W;

   logic [SQ_W-1:0] sq;
   logic [SQ_W-1:0] rounded;

   always_comb begin
      sq = '0;
      for (int i = 0; i < DUTY_W; i++) begin
         if (x[i]) sq = sq + ({{DUTY_W{1'b0}}, x} << i);
      end
   end

   // 255*255 + 255 = 65280 still fits in 16 bits, so no carry is lost
   assign rounded = sq + SQ_W'(255);
   assign y       = rounded[SQ_W-1:DUTY_W];
endmodule

// File: rtl/rgbw_duty_fader.sv
// Per-channel duty slew limiter between colorGen and pwmGen.
// Optional gamma output stage: RGBW_FADER_GAMMA_LUT_EN.
module rgbw_duty_fader
   import rgbw_pkg::*;
#(
   parameter int unsigned STEP_DIV  = 255,
   parameter int unsigned STEP_SIZE = 1
)(
   input  logic             clk,
   input  logic             reset,
   rgbw_duty_fader_if.slave bus
);
   localparam logic [DUTY_W-1:0] DIV_LAST = DUTY_W'(STEP_DIV - 1);
   localparam logic [DUTY_W:0]   STEP9    = (DUTY_W+1)'(STEP_SIZE);
   localparam logic [DUTY_W-1:0] STEP8    = DUTY_W'(STEP_SIZE);

   logic [DUTY_W-1:0] pcnt;
   logic [DUTY_W-1:0] pcnt_eff;
   logic              fade_q;
   logic              settled_r;
   logic              step_tick;
   logic [N_CH-1:0]   ch_eq;

   duty_t tgt    [N_CH];
   duty_t duty_q [N_CH];

   assign tgt[RED]   = bus.target0;
   assign tgt[GREEN] = bus.target1;
   assign tgt[BLUE]  = bus.target2;
   assign tgt[WHITE] = bus.target3;

   // A fresh entry into ramp mode counts from zero regardless of stale pcnt
   assign pcnt_eff  = fade_q ? pcnt : '0;
   assign step_tick = bus.fade_en && (pcnt_eff == DIV_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt      <= '0;
         fade_q    <= 1'b0;
         settled_r <= 1'b0;
      end else if (bus.clk_half) begin
         fade_q    <= bus.fade_en;
         settled_r <= &ch_eq;
         if (!bus.fade_en)   pcnt <= '0;
         else if (step_tick) pcnt <= '0;
         else                pcnt <= pcnt_eff + 8'd1;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      duty_t          d_r;
      duty_t          d_step;
      logic [DUTY_W:0] dist_up;
      logic [DUTY_W:0] dist_dn;

      always_comb begin
         dist_up = {1'b0, tgt[i]} - {1'b0, d_r};
         dist_dn = {1'b0, d_r} - {1'b0, tgt[i]};
         d_step  = d_r;
         // Clamp to the remaining distance so a step never overshoots or wraps
         if (d_r < tgt[i])      d_step = (dist_up > STEP9) ? d_r + STEP8 : tgt[i];
         else if (d_r > tgt[i]) d_step = (dist_dn > STEP9) ? d_r - STEP8 : tgt[i];
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            d_r <= '0;
         end else if (bus.clk_half) begin
            if (!bus.fade_en)   d_r <= tgt[i];
            else if (step_tick) d_r <= d_step;
         end
      end

      assign ch_eq[i] = (d_r == tgt[i]);

`ifdef RGBW_FADER_GAMMA_LUT_EN
      duty_t g_val;
      duty_t duty_r;

      rgbw_gamma_lut u_gamma (
         .x (d_r),
         .y (g_val)
      );

      always_ff @(posedge clk) begin
         if (reset)             duty_r <= '0;
         else if (bus.clk_half) duty_r <= g_val;
      end

      assign duty_q[i] = duty_r;
`else
      assign duty_q[i] = d_r;
`endif
   end

   assign bus.duty0   = duty_q[RED];
   assign bus.duty1   = duty_q[GREEN];
   assign bus.duty2   = duty_q[BLUE];
   assign bus.duty3   = duty_q[WHITE];
   assign bus.settled = settled_r;
endmodule

// File: tb/tb_rgbw_duty_fader.sv
// Bench for rgbw_duty_fader: directed ramp/snap/freeze cases then random traffic,
// all outputs compared every cycle against a count-since-ramp-entry reference model.
module tb_rgbw_duty_fader;
   import rgbw_pkg::*;

   localparam int DIV = 4;
   localparam int SSZ = 16;

   logic clk = 1'b0;
   logic reset;

   rgbw_duty_fader_if bus ();

   rgbw_duty_fader #(
      .STEP_DIV  (DIV),
      .STEP_SIZE (SSZ)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   bit ch_half;
   bit fade;
   int tgt [N_CH];

   int m_d   [N_CH];
   int m_out [N_CH];
   int m_cnt;
   bit m_fading;
   bit m_settled;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int gamma_ref(input int x);
      return (x * x + 255) / 256;
   endfunction

   function automatic int approach(input int cur, input int goal);
      int diff;
      diff = goal - cur;
      if (diff > SSZ)       return cur + SSZ;
      else if (diff < -SSZ) return cur - SSZ;
      else                  return goal;
   endfunction

   task automatic model_step();
      bit all_eq;
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            m_d[i]   = 0;
            m_out[i] = 0;
         end
         m_cnt     = 0;
         m_fading  = 1'b0;
         m_settled = 1'b0;
      end else if (ch_half) begin
         all_eq = 1'b1;
         for (int i = 0; i < N_CH; i++) begin
            if (m_d[i] != tgt[i]) all_eq = 1'b0;
            m_out[i] = gamma_ref(m_d[i]);
         end
         if (!fade) begin
            for (int i = 0; i < N_CH; i++) m_d[i] = tgt[i];
            m_cnt = 0;
         end else begin
            if (!m_fading) m_cnt = 0;
            m_cnt++;
            if (m_cnt % DIV == 0)
               for (int i = 0; i < N_CH; i++) m_d[i] = approach(m_d[i], tgt[i]);
         end
         m_fading  = fade;
         m_settled = all_eq;
      end
   endtask

   task automatic compare();
      int obs [N_CH];
      int exp_v;
      obs[RED]   = int'(bus.duty0);
      obs[GREEN] = int'(bus.duty1);
      obs[BLUE]  = int'(bus.duty2);
      obs[WHITE] = int'(bus.duty3);
      for (int i = 0; i < N_CH; i++) begin
`ifdef RGBW_FADER_GAMMA_LUT_EN
         exp_v = m_out[i];
`else
         exp_v = m_d[i];
`endif
         check_val($sformatf("model_duty%0d", i), obs[i], exp_v);
      end
      check_val("model_settled", int'(bus.settled), int'(m_settled));
   endtask

   task automatic tick();
      bus.clk_half = ch_half;
      bus.fade_en  = fade;
      bus.target0  = 8'(tgt[RED]);
      bus.target1  = 8'(tgt[GREEN]);
      bus.target2  = 8'(tgt[BLUE]);
      bus.target3  = 8'(tgt[WHITE]);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      bit found;
      reset   = 1'b1;
      ch_half = 1'b1;
      fade    = 1'b0;
      for (int i = 0; i < N_CH; i++) tgt[i] = 'h55;

      // reset with targets at 0x55, then snap
      run(2);
      check_val("rst_duty0", int'(bus.duty0), 0);
      check_val("rst_settled", int'(bus.settled), 0);
      reset = 1'b0;
      tick();
`ifndef RGBW_FADER_GAMMA_LUT_EN
      check_val("snap_duty3", int'(bus.duty3), 'h55);
`endif
      check_val("snap_settled_lag", int'(bus.settled), 0);
      tick();
      check_val("snap_settled", int'(bus.settled), 1);

      // ramp 0 -> 0x40
      for (int i = 0; i < N_CH; i++) tgt[i] = 0;
      run(2);
      fade     = 1'b1;
      tgt[RED] = 'h40;
      for (int k = 1; k <= 17; k++) begin
         tick();
`ifndef RGBW_FADER_GAMMA_LUT_EN
         if (k % DIV == 0) check_val("ramp_up", int'(bus.duty0), 16 * (k / DIV));
`endif
         if (k == 16) check_val("ramp_settled_early", int'(bus.settled), 0);
      end
      check_val("ramp_settled", int'(bus.settled), 1);

      // clamped steps, no wrap below zero
      tgt[RED] = 'h45;
      run(DIV);
`ifndef RGBW_FADER_GAMMA_LUT_EN
      check_val("clamp_up", int'(bus.duty0), 'h45);
`endif
      tgt[RED] = 'h05;
      run(4 * DIV);
      tgt[RED] = 'h00;
      run(DIV);
`ifndef RGBW_FADER_GAMMA_LUT_EN
      check_val("clamp_zero", int'(bus.duty0), 'h00);
`endif

      // retarget mid-ramp
      tgt[RED] = 'hFF;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         tick();
         if (m_d[RED] == 'h30) found = 1'b1;
      end
      check_val("wait_0x30", int'(found), 1);
      tgt[RED] = 'h10;
      run(DIV);
`ifndef RGBW_FADER_GAMMA_LUT_EN
      check_val("retarget_1", int'(bus.duty0), 'h20);
`endif
      run(DIV);
`ifndef RGBW_FADER_GAMMA_LUT_EN
      check_val("retarget_2", int'(bus.duty0), 'h10);
`endif
      run(2 * DIV);
`ifndef RGBW_FADER_GAMMA_LUT_EN
      check_val("retarget_hold", int'(bus.duty0), 'h10);
`endif

      // freeze via clk_half, then drop fade_en
      tgt[RED]   = 'hC0;
      tgt[GREEN] = 'h80;
      run(6);
      ch_half = 1'b0;
      run(10);
      ch_half = 1'b1;
      run(2 * DIV);
      fade = 1'b0;
      tick();
`ifndef RGBW_FADER_GAMMA_LUT_EN
      check_val("drop_fade0", int'(bus.duty0), 'hC0);
      check_val("drop_fade1", int'(bus.duty1), 'h80);
`endif

      // reset mid-ramp
      fade     = 1'b1;
      tgt[RED] = 'h00;
      run(5);
      reset = 1'b1;
      tick();
      check_val("midramp_rst_duty1", int'(bus.duty1), 0);
      check_val("midramp_rst_settled", int'(bus.settled), 0);
      reset = 1'b0;

`ifdef RGBW_FADER_GAMMA_LUT_EN
      fade     = 1'b0;
      tgt[RED] = 'h80;
      run(2);
      check_val("gamma_80", int'(bus.duty0), 'h40);
      tgt[RED] = 'hFF;
      run(2);
      check_val("gamma_ff", int'(bus.duty0), 'hFF);
      tgt[RED] = 'h01;
      run(2);
      check_val("gamma_01", int'(bus.duty0), 'h01);
`endif

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         reset   = ($urandom_range(199) == 0);
         ch_half = ($urandom_range(3) != 0);
         if ($urandom_range(49) == 0) fade = ~fade;
         for (int i = 0; i < N_CH; i++)
            if ($urandom_range(19) == 0) tgt[i] = int'($urandom_range(255));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
